// File: rtl/quad_pkg.sv
// Shared constants for the quadrature decoder:
// resolution modes and decoder state encoding.
package quad_pkg;

    localparam logic [1:0] MODE_X4 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X1 = 2'b10;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/quad_decoder_if.sv
// Pin and control bundle of the quadrature decoder.
// master drives encoder pins/controls, slave is the decoder.
interface quad_decoder_if #(
    parameter int WIDTH = 8
);
    logic             a;
    logic             b;
    logic [1:0]       mode;
    logic             sat_en;
    logic             clear;
    logic             load_en;
    logic [WIDTH-1:0] load_value;
    logic             err_clr;
    logic [WIDTH-1:0] value;
    logic             dir;
    logic             step;
    logic             ovf;
    logic             err;

    modport master (
        output a, b, mode, sat_en,
        output clear, load_en,
        output load_value, err_clr,
        input  value, dir, step,
        input  ovf, err
    );

    modport slave (
        input  a, b, mode, sat_en,
        input  clear, load_en,
        input  load_value, err_clr,
        output value, dir, step,
        output ovf, err
    );
endinterface

// File: rtl/glitch_filter.sv
// Level filter: accepts a new level only after it has been
// seen on FILTER_LEN consecutive edges; bypass follows input.
module glitch_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_bypass,
    input  logic i_in,
    output logic o_level
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_done;

    assign w_done  = (r_cnt == CW'(FILTER_LEN - 1));
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (i_bypass) begin
            r_level <= i_in;
            r_cnt   <= '0;
        end else if (i_in != r_level) begin
            if (w_done) begin
                r_level <= i_in;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end
endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: sync + glitch filter per channel,
// x1/x2/x4 gray decode, wrap/saturate position counter.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input logic           clk,
    input logic           reset,
    quad_decoder_if.slave bus
);
    localparam int INIT_CYC = SYNC_STAGES + FILTER_LEN + 1;
    localparam int ICW      = $clog2(INIT_CYC + 1);

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [ICW-1:0]         r_init_cnt;
    state_t                 r_state;
    state_t                 w_next;
    logic                   w_run;
    logic                   w_bypass;
    logic                   w_init_done;
    logic                   w_fa;
    logic                   w_fb;
    logic                   r_prev_a;
    logic                   r_prev_b;
    logic                   w_da;
    logic                   w_db;
    logic                   w_illegal;
    logic                   w_ev;
    logic                   w_up;
    logic                   w_wrap;
    logic [WIDTH-1:0]       r_value;
    logic                   r_dir;
    logic                   r_step;
    logic                   r_ovf;
    logic                   r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], bus.a};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], bus.b};
        end
    end

    glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk      (clk),
        .reset    (reset),
        .i_bypass (w_bypass),
        .i_in     (r_sync_a[SYNC_STAGES-1]),
        .o_level  (w_fa)
    );

    glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk      (clk),
        .reset    (reset),
        .i_bypass (w_bypass),
        .i_in     (r_sync_b[SYNC_STAGES-1]),
        .o_level  (w_fb)
    );

    assign w_init_done = (r_init_cnt == ICW'(INIT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_INIT: if (w_init_done) w_next = ST_RUN;
            ST_RUN:  w_next = ST_RUN;
            default: w_next = ST_INIT;
        endcase
    end

    always_comb begin
        w_run    = (r_state == ST_RUN);
        w_bypass = ~w_run;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_init_cnt <= '0;
        else if (!w_run && !w_init_done)
            r_init_cnt <= r_init_cnt + ICW'(1);
    end

    // prev tracks filtered levels in every mode and state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_a <= 1'b0;
            r_prev_b <= 1'b0;
        end else begin
            r_prev_a <= w_fa;
            r_prev_b <= w_fb;
        end
    end

    assign w_da      = w_fa ^ r_prev_a;
    assign w_db      = w_fb ^ r_prev_b;
    assign w_illegal = w_run & w_da & w_db;

    always_comb begin
        w_ev = 1'b0;
        w_up = 1'b0;
        if (w_run && !w_illegal) begin
            case (bus.mode)
                MODE_X1: begin
                    w_ev = w_da & ~w_fb;
                    w_up = w_fa;
                end
                MODE_X2: begin
                    w_ev = w_da;
                    w_up = w_fa ^ w_fb;
                end
                default: begin
                    w_ev = w_da | w_db;
                    w_up = w_da ? (w_fa ^ w_fb)
                                : ~(w_fa ^ w_fb);
                end
            endcase
        end
    end

    assign w_wrap = w_up ? (r_value == '1) : (r_value == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_dir   <= 1'b0;
            r_step  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_ovf  <= 1'b0;
            if (bus.clear) begin
                r_value <= '0;
            end else if (bus.load_en) begin
                r_value <= bus.load_value;
            end else if (w_ev) begin
                r_step <= 1'b1;
                r_dir  <= w_up;
                r_ovf  <= w_wrap;
                if (!(w_wrap && bus.sat_en))
                    r_value <= w_up ? r_value + WIDTH'(1)
                                    : r_value - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)            r_err <= 1'b0;
        else if (w_illegal)   r_err <= 1'b1;
        else if (bus.err_clr) r_err <= 1'b0;
    end

    assign bus.value = r_value;
    assign bus.dir   = r_dir;
    assign bus.step  = r_step;
    assign bus.ovf   = r_ovf;
    assign bus.err   = r_err;
endmodule

// File: tb/tb_quad_decoder.sv
// Directed + random bench for quad_decoder against a
// position-index model of the encoder gray sequence.
module tb_quad_decoder;
    localparam int MAXV = 255;

    logic clk = 1'b0;
    logic reset;

    quad_decoder_if #(.WIDTH(8)) bus();

    quad_decoder #(
        .WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int npass = 0;
    int nfail = 0;
    int nsteps = 0;

    // model state
    logic [1:0] cur;
    int         exp_val;
    logic       exp_dir;
    logic       exp_err;
    int         exp_steps;

    always @(negedge clk) if (bus.step === 1'b1) nsteps++;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, expv);
        end
    endtask

    // position of an AB level along the forward sequence
    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model(input logic [1:0] nab);
        int   d;
        logic up;
        logic achg;
        logic cnt;
        int   nv;
        d = (gidx(nab) - gidx(cur) + 4) % 4;
        achg = nab[1] != cur[1];
        if (d == 2) begin
            exp_err = 1'b1;
        end else if (d != 0) begin
            up = (d == 1);
            case (bus.mode)
                2'b01: cnt = achg;
                2'b10: begin
                    cnt = achg && !nab[0];
                    up  = nab[1];
                end
                default: cnt = 1'b1;
            endcase
            if (cnt) begin
                exp_steps++;
                exp_dir = up;
                nv = up ? exp_val + 1 : exp_val - 1;
                if (nv < 0)
                    nv = bus.sat_en ? 0 : MAXV;
                else if (nv > MAXV)
                    nv = bus.sat_en ? MAXV : 0;
                exp_val = nv;
            end
        end
        cur = nab;
    endtask

    task automatic drive(input logic [1:0] ab);
        bus.a = ab[1];
        bus.b = ab[0];
        model(ab);
    endtask

    task automatic go(input logic [1:0] ab, input int hold);
        drive(ab);
        cyc(hold);
    endtask

    task automatic do_reset(input logic [1:0] ab);
        reset = 1'b1;
        bus.a = ab[1];
        bus.b = ab[0];
        cur = ab;
        exp_val = 0;
        exp_dir = 1'b0;
        exp_err = 1'b0;
        cyc(2);
    endtask

    logic [1:0] seq [4];
    int         sv;
    int         ssteps;
    logic       sdir;
    logic [1:0] nab;
    int         r;
    logic [7:0] edge_vals [4];

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b10;
        seq[2] = 2'b11; seq[3] = 2'b01;
        edge_vals[0] = 8'h00; edge_vals[1] = 8'h01;
        edge_vals[2] = 8'hFE; edge_vals[3] = 8'hFF;
        exp_steps = 0;
        bus.mode = 2'b00;
        bus.sat_en = 1'b0;
        bus.clear = 1'b0;
        bus.load_en = 1'b0;
        bus.load_value = '0;
        bus.err_clr = 1'b0;

        // 1: reset with both channels high
        do_reset(2'b11);
        chk("rst_value", 32'(bus.value), 0);
        chk("rst_dir", 32'(bus.dir), 0);
        chk("rst_step", 32'(bus.step), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_err", 32'(bus.err), 0);
        reset = 1'b0;
        cyc(20);
        chk("init11_value", 32'(bus.value), 0);
        chk("init11_err", 32'(bus.err), 0);
        chk("init11_steps", nsteps, 0);

        do_reset(2'b00);
        reset = 1'b0;
        cyc(10);

        // 2: x4 forward cycle with latency
        drive(2'b10);
        cyc(5);
        chk("lat_before", 32'(bus.value), 0);
        cyc(1);
        chk("lat_value", 32'(bus.value), 1);
        chk("lat_step", 32'(bus.step), 1);
        chk("lat_dir", 32'(bus.dir), 1);
        cyc(4);
        go(2'b11, 10);
        go(2'b01, 10);
        go(2'b00, 10);
        chk("fwd4_value", 32'(bus.value), 4);
        chk("fwd4_dir", 32'(bus.dir), 1);
        chk("fwd4_steps", nsteps, 4);

        // 3: reverse step from zero, wrap then saturate
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        exp_val = 0;
        chk("clr_value", 32'(bus.value), 0);
        chk("clr_dir_kept", 32'(bus.dir), 1);
        drive(2'b01);
        cyc(6);
        chk("wrap_value", 32'(bus.value), 255);
        chk("wrap_ovf", 32'(bus.ovf), 1);
        chk("wrap_dir", 32'(bus.dir), 0);
        cyc(4);
        go(2'b00, 10);
        chk("wrap_back", 32'(bus.value), 0);
        bus.sat_en = 1'b1;
        drive(2'b01);
        cyc(6);
        chk("sat_value", 32'(bus.value), 0);
        chk("sat_step", 32'(bus.step), 1);
        chk("sat_ovf", 32'(bus.ovf), 1);
        cyc(4);
        go(2'b00, 10);
        chk("sat_back", 32'(bus.value), exp_val);
        bus.sat_en = 1'b0;

        // 4: glitch filter
        sv = exp_val;
        ssteps = nsteps;
        bus.a = 1'b1;
        cyc(2);
        bus.a = 1'b0;
        cyc(10);
        chk("glitch_value", 32'(bus.value), sv);
        chk("glitch_steps", nsteps, ssteps);
        bus.a = 1'b1;
        cyc(3);
        bus.a = 1'b0;
        cyc(3);
        chk("pulse3_up", 32'(bus.value), sv + 1);
        cyc(3);
        chk("pulse3_down", 32'(bus.value), sv);
        chk("pulse3_dir", 32'(bus.dir), 0);
        cyc(5);
        exp_steps += 2;
        exp_dir = 1'b0;

        // 5: illegal transitions and err_clr
        sv = exp_val;
        go(2'b11, 7);
        chk("ill_err", 32'(bus.err), 1);
        chk("ill_value", 32'(bus.value), sv);
        bus.err_clr = 1'b1;
        cyc(1);
        bus.err_clr = 1'b0;
        exp_err = 1'b0;
        chk("errclr", 32'(bus.err), 0);
        bus.err_clr = 1'b1;
        drive(2'b00);
        cyc(6);
        bus.err_clr = 1'b0;
        cyc(3);
        chk("ill_set_wins", 32'(bus.err), 1);
        chk("ill_value2", 32'(bus.value), sv);
        bus.err_clr = 1'b1;
        cyc(1);
        bus.err_clr = 1'b0;
        exp_err = 1'b0;

        // 6: x1 / x2 resolution, load and clear
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        exp_val = 0;
        bus.mode = 2'b10;
        for (int k = 0; k < 8; k++) go(seq[(k + 1) % 4], 9);
        chk("x1_value", 32'(bus.value), 2);
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        exp_val = 0;
        bus.mode = 2'b01;
        for (int k = 0; k < 8; k++) go(seq[(k + 1) % 4], 9);
        chk("x2_value", 32'(bus.value), 4);
        ssteps = exp_steps;
        sdir = exp_dir;
        drive(2'b10);
        exp_steps = ssteps;
        exp_dir = sdir;
        cyc(5);
        bus.load_en = 1'b1;
        bus.load_value = 8'hF0;
        cyc(1);
        bus.load_en = 1'b0;
        exp_val = 'hF0;
        chk("load_value", 32'(bus.value), 'hF0);
        chk("load_nostep", 32'(bus.step), 0);
        cyc(4);
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        exp_val = 0;
        chk("clear_value", 32'(bus.value), 0);
        chk("steps_sofar", nsteps, exp_steps);

        // random walk with mode/sat changes
        for (int it = 0; it < 48; it++) begin
            if (it % 12 == 0) begin
                bus.load_value = edge_vals[(it / 12) % 4];
                bus.load_en = 1'b1;
                cyc(1);
                bus.load_en = 1'b0;
                exp_val = int'(bus.load_value);
            end
            bus.mode = 2'($urandom_range(0, 3));
            bus.sat_en = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 11);
            if (r == 0)
                nab = cur ^ 2'b11;
            else if (r < 6)
                nab = seq[(gidx(cur) + 1) % 4];
            else
                nab = seq[(gidx(cur) + 3) % 4];
            go(nab, $urandom_range(8, 12));
            chk("rnd_value", 32'(bus.value), exp_val);
            chk("rnd_dir", 32'(bus.dir), 32'(exp_dir));
            chk("rnd_err", 32'(bus.err), 32'(exp_err));
            chk("rnd_steps", nsteps, exp_steps);
        end

        // reset mid-operation
        bus.mode = 2'b00;
        drive(seq[(gidx(cur) + 1) % 4]);
        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("midrst_value", 32'(bus.value), 0);
        chk("midrst_dir", 32'(bus.dir), 0);
        chk("midrst_err", 32'(bus.err), 0);
        reset = 1'b0;
        cyc(12);
        chk("midrst_init", 32'(bus.value), 0);

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end
endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
Parametrised quadrature decoder for incremental encoders with A/B inputs. It synchronises and glitch-filters the raw A/B pins, then decodes gray-code transitions in x1, x2 or x4 resolution into an up/down position counter. The counter can wrap or saturate, and supports clear and load. It reports direction, per-count step pulses, overflow pulses and a sticky error flag for illegal transitions. It replaces the fixed 8-bit single-mode encoder counter in the user-peripheral area.

Parameters:
WIDTH, 8, position counter width in bits (2..32)
SYNC_STAGES, 2, input synchroniser depth (>=2)
FILTER_LEN, 3, consecutive samples needed to accept a new input level (>=1; 1 = no filtering)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
a  in  1  raw encoder channel A (asynchronous)
b  in  1  raw encoder channel B (asynchronous)
mode  in  2  resolution: 00 x4, 01 x2, 10 x1, 11 treated as x4
sat_en  in  1  1 = saturate at 0 / 2^WIDTH-1; 0 = wrap
clear  in  1  zero the counter
load_en  in  1  load counter from load_value
load_value  in  WIDTH  value to load
err_clr  in  1  clear sticky err
value  out  WIDTH  unsigned position count
dir  out  1  direction of last counted event (1 = up)
step  out  1  one-cycle pulse per decoded count event
ovf  out  1  one-cycle pulse when a count wraps or is clipped by saturation
err  out  1  sticky illegal-transition flag

Behaviour:
- Reset: value=0, dir=0, step=0, ovf=0, err=0; synchroniser and filter registers =0; state machine enters INIT.
- Synchroniser: SYNC_STAGES flops per channel.
- Filter, per channel: the filtered level takes a new value on the edge where the synchronised level has differed from it on FILTER_LEN consecutive edges. A shorter pulse is ignored and the run count restarts.
- State machine:
  - INIT: lasts SYNC_STAGES+FILTER_LEN+1 cycles after reset deasserts. Filters pass the synchronised level straight through. prev_a/prev_b track the filtered level. No counting; err is not set; clear/load are still honoured.
  - RUN: normal decoding. RUN is left only on reset.
- Forward sequence (AB): 00→10→11→01→00. Reverse is the opposite order.
- x4: every single-channel transition counts. +1 for: A rise with B=0, A fall with B=1, B rise with A=1, B fall with A=0. The inverse transitions count -1.
- x2: only A transitions count, with the same signs as x4.
- x1: +1 on A rise with B=0; -1 on A fall with B=0; nothing else counts.
- Illegal transition (A and B both change in one cycle, RUN only): no count, step=0, err set. If err_clr arrives in the same cycle, set wins.
- Latency: raw input change → value/step/dir update on edge SYNC_STAGES+FILTER_LEN+1 (6 with defaults).
- Counter priority per edge: reset > clear > load_en > count event.
  - clear or load suppresses a coincident count: no step, no ovf.
  - dir is unchanged by clear/load.
- Arithmetic: unsigned WIDTH bits.
  - sat_en=0: wraps modulo 2^WIDTH; ovf pulses on wrap.
  - sat_en=1: value holds at the bound; step and ovf still pulse, and dir still updates.
- Changes to mode and sat_en take effect on the next edge. prev_a/prev_b always track the filtered levels regardless of mode, so a mode change causes no spurious count.
- Reset asserted mid-operation: all state returns to reset values on that edge, and the block re-enters INIT.

Decomposition:
- Package quad_pkg holds the mode constants MODE_X4=2'b00, MODE_X2=2'b01, MODE_X1=2'b10 and the state encoding (INIT, RUN).
- Sub-module glitch_filter (parameter FILTER_LEN, with bypass input for INIT) is instantiated once per channel.
- Synchroniser, decode logic and counter live in quad_decoder.

Test Plan:
1. Reset with a=b=1 held, run 20 cycles → value=0, err=0, step never pulses.
2. x4, defaults: AB 00,10,11,01,00, each level held 10 cycles → value=4, dir=1, 4 step pulses; first update 6 cycles after a rises.
3. x4 from value=0, one reverse step: sat_en=0 → value=255, dir=0, ovf pulse. Repeat with sat_en=1 → value=0, step and ovf pulse.
4. FILTER_LEN=3: a high for 2 cycles → no change. a high for 3 cycles then low (b=0) → value +1 then back to 0, dir=0.
5. a and b toggled on the same cycle → err=1, value unchanged. err_clr alone → err=0. err_clr coincident with another illegal transition → err stays 1.
6. Two full forward cycles → value 2 in x1, 4 in x2. load_en with load_value=8'hF0 coincident with a count → value=F0, no step. clear → value=0.
